rv32_seq_ctrl: RTL and testbench

RV32_SEQ_CTRL -- requirements
Module: rv32_seq_ctrl

---
 rtl/rv32_seq_pkg.sv | 57 +++++
 rtl/rv32_perf_cnt.sv | 34 +++
 rtl/rv32_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rv32_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_seq_pkg.sv
// -----------------------------------------------------------------------------
// rv32_seq_pkg -- shared definitions for the RV32I multi-cycle sequencer.
//   state_e     : 3-bit controller state encoding (driven on the 'state' port)
//   op_class_e  : dispatch class of an opcode as seen in EXEC
//   OP_*        : RV32I major opcode constants (instr[6:0])
//   classify_op : maps {op, func3} to an op_class_e
// -----------------------------------------------------------------------------
package rv32_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // How EXEC leaves: through MEM, through WB, straight back to FETCH
  // (retire-only), into HALT as an environment call, or as an illegal op.
  typedef enum logic [2:0] {
    OPC_MEM,
    OPC_WB,
    OPC_RETIRE,
    OPC_ENV,
    OPC_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify_op(input logic [6:0] op,
                                            input logic [2:0] func3);
    op_class_e c;
    c = OPC_ILLEGAL;
    case (op)
      OP_LOAD, OP_STORE:                 c = OPC_MEM;
      OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM,
      OP_JAL, OP_JALR:                   c = OPC_WB;
      OP_BRANCH, OP_FENCE:               c = OPC_RETIRE;
      // Only ecall/ebreak (func3=0) are supported; CSR forms are illegal.
      OP_SYSTEM:                         c = (func3 == 3'b000) ? OPC_ENV : OPC_ILLEGAL;
      default:                           c = OPC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv32_perf_cnt.sv
// -----------------------------------------------------------------------------
// rv32_perf_cnt -- free-running cycle and retired-instruction counters.
//   clock       : rising-edge clock
//   reset       : synchronous active-high clear
//   retire      : one pulse per retired instruction (the sequencer's pc_we)
//   cycle_cnt   : non-reset cycles since reset, wraps at 2^32
//   instret_cnt : retired instructions since reset, wraps at 2^32
// -----------------------------------------------------------------------------
module rv32_perf_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      // Natural 32-bit overflow gives the required wrap to zero.
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/rv32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rv32_seq_ctrl -- multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT).
//
// Parameter
//   HALT_ON_ILLEGAL : 1 = illegal opcode enters HALT with 'illegal' set,
//                     0 = illegal opcode retires as a NOP.
// Build option
//   RV32_SEQ_PERF_EN : when defined, instantiates rv32_perf_cnt; otherwise the
//                      counter outputs are tied to zero and no counter exists.
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   op, func3               : opcode / func3 of the externally latched IR
//   imem_ready, dmem_ready  : memory handshakes (only observed while waiting)
//   resume                  : leave HALT
//   imem_re, ir_we          : fetch request, instruction register load
//   pc_we                   : one pulse per retired instruction
//   rf_we                   : register-file write, only in WB
//   dmem_re, dmem_we        : data read / write request, only in MEM
//   halted, illegal         : in HALT / HALT caused by an illegal opcode
//   state                   : current state encoding (rv32_seq_pkg::state_e)
//   cycle_cnt, instret_cnt  : performance counters
// -----------------------------------------------------------------------------
module rv32_seq_ctrl
  import rv32_seq_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        resume,
  output logic        imem_re,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_e state_q, state_d;
  logic   illegal_q;
  logic   set_illegal, clr_illegal;
  logic   imem_re_c, ir_we_c, pc_we_c, rf_we_c, dmem_re_c, dmem_we_c;
  logic   is_store;

  assign is_store = (op == OP_STORE);

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d     = state_q;
    imem_re_c   = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    rf_we_c     = 1'b0;
    dmem_re_c   = 1'b0;
    dmem_we_c   = 1'b0;
    set_illegal = 1'b0;
    clr_illegal = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_re_c = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = ST_EXEC;

      ST_EXEC: begin
        case (classify_op(op, func3))
          OPC_MEM:    state_d = ST_MEM;
          OPC_WB:     state_d = ST_WB;
          OPC_ENV:    state_d = ST_HALT;
          OPC_RETIRE: begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            if (HALT_ON_ILLEGAL) begin
              set_illegal = 1'b1;
              state_d     = ST_HALT;
            end else begin
              pc_we_c = 1'b1;
              state_d = ST_FETCH;
            end
          end
        endcase
      end

      ST_MEM: begin
        // Exactly one of read/write, selected by the latched opcode.
        dmem_we_c = is_store;
        dmem_re_c = !is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        // The halting instruction retires on resume.
        if (resume) begin
          pc_we_c     = 1'b1;
          clr_illegal = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal)      illegal_q <= 1'b1;
      else if (clr_illegal) illegal_q <= 1'b0;
    end
  end

  // Reset is synchronous, so the registered state is still live during the
  // reset cycle; gating here drops any outstanding request in that cycle.
  assign imem_re = imem_re_c & ~reset;
  assign ir_we   = ir_we_c   & ~reset;
  assign pc_we   = pc_we_c   & ~reset;
  assign rf_we   = rf_we_c   & ~reset;
  assign dmem_re = dmem_re_c & ~reset;
  assign dmem_we = dmem_we_c & ~reset;
  assign halted  = (state_q == ST_HALT) & ~reset;
  assign illegal = illegal_q & ~reset;
  assign state   = state_q;

`ifdef RV32_SEQ_PERF_EN
  rv32_perf_cnt u_perf (
    .clock       (clock),
    .reset       (reset),
    .retire      (pc_we),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_rv32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32_seq_ctrl -- directed vectors for rv32_seq_ctrl. A table walks one
// continuous instruction stream cycle by cycle; hand sequences cover the
// illegal-opcode variants, reset in the middle of MEM and counter wrap.
// dut uses HALT_ON_ILLEGAL=1, dut0 uses HALT_ON_ILLEGAL=0 on the same inputs.
// -----------------------------------------------------------------------------
module tb_rv32_seq_ctrl;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                         S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

  localparam logic [6:0] C_LOAD = 7'b0000011, C_STORE = 7'b0100011,
                         C_BR   = 7'b1100011, C_JAL   = 7'b1101111,
                         C_LUI  = 7'b0110111, C_ADD   = 7'b0110011,
                         C_FEN  = 7'b0001111, C_SYS   = 7'b1110011,
                         C_BAD  = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = '0;
  logic [2:0]  func3 = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, resume = 1'b0;

  logic        imem_re, ir_we, pc_we, rf_we, dmem_re, dmem_we, halted, illegal;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        imem_re0, ir_we0, pc_we0, rf_we0, dmem_re0, dmem_we0, halted0, illegal0;
  logic [2:0]  state0;
  logic [31:0] cycle_cnt0, instret_cnt0;

  int checks = 0;
  int failures = 0;

  rv32_seq_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .op(op), .func3(func3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
    .imem_re(imem_re), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted), .illegal(illegal),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  rv32_seq_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clock(clock), .reset(reset), .op(op), .func3(func3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
    .imem_re(imem_re0), .ir_we(ir_we0), .pc_we(pc_we0), .rf_we(rf_we0),
    .dmem_re(dmem_re0), .dmem_we(dmem_we0), .halted(halted0), .illegal(illegal0),
    .state(state0), .cycle_cnt(cycle_cnt0), .instret_cnt(instret_cnt0)
  );

  always #5 clock = ~clock;

  // Strobe bundle order: {imem_re, ir_we, pc_we, rf_we, dmem_re, dmem_we, halted, illegal}
  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        ir;
    logic        dr;
    logic        res;
    logic [2:0]  st;
    logic [7:0]  strb;
    logic [31:0] cyc;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[38];

  function automatic logic [7:0] strobes();
    return {imem_re, ir_we, pc_we, rf_we, dmem_re, dmem_we, halted, illegal};
  endfunction

  // Counters read zero in the default build.
  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef RV32_SEQ_PERF_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic drive(input logic rst, input logic [6:0] o, input logic [2:0] f,
                       input logic ir, input logic dr, input logic res);
    @(negedge clock);
    reset = rst; op = o; func3 = f;
    imem_ready = ir; dmem_ready = dr; resume = res;
    #1;
  endtask

  initial begin
    //              rst   op       f3    ir    dr    res   st   strobes       cyc     ret
    tbl[0]  = '{1'b1, C_ADD,   3'd0, 1'b0, 1'b0, 1'b0, S_F, 8'b0000_0000, 32'd0,  32'd0};
    tbl[1]  = '{1'b0, C_ADD,   3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd0,  32'd0};
    tbl[2]  = '{1'b0, C_ADD,   3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd1,  32'd0};
    tbl[3]  = '{1'b0, C_ADD,   3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0000_0000, 32'd2,  32'd0};
    tbl[4]  = '{1'b0, C_ADD,   3'd0, 1'b1, 1'b1, 1'b0, S_W, 8'b0011_0000, 32'd3,  32'd0};
    tbl[5]  = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd4,  32'd1};
    tbl[6]  = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd5,  32'd1};
    tbl[7]  = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b0, 1'b0, S_E, 8'b0000_0000, 32'd6,  32'd1};
    tbl[8]  = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b0, 1'b0, S_M, 8'b0000_1000, 32'd7,  32'd1};
    tbl[9]  = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b0, 1'b0, S_M, 8'b0000_1000, 32'd8,  32'd1};
    tbl[10] = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b0, 1'b0, S_M, 8'b0000_1000, 32'd9,  32'd1};
    tbl[11] = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b1, 1'b0, S_M, 8'b0000_1000, 32'd10, 32'd1};
    tbl[12] = '{1'b0, C_LOAD,  3'd0, 1'b1, 1'b1, 1'b0, S_W, 8'b0011_0000, 32'd11, 32'd1};
    tbl[13] = '{1'b0, C_STORE, 3'd0, 1'b0, 1'b0, 1'b0, S_F, 8'b1000_0000, 32'd12, 32'd2};
    tbl[14] = '{1'b0, C_STORE, 3'd0, 1'b1, 1'b0, 1'b0, S_F, 8'b1100_0000, 32'd13, 32'd2};
    tbl[15] = '{1'b0, C_STORE, 3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd14, 32'd2};
    tbl[16] = '{1'b0, C_STORE, 3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0000_0000, 32'd15, 32'd2};
    tbl[17] = '{1'b0, C_STORE, 3'd0, 1'b1, 1'b1, 1'b0, S_M, 8'b0010_0100, 32'd16, 32'd2};
    tbl[18] = '{1'b0, C_BR,    3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd17, 32'd3};
    tbl[19] = '{1'b0, C_BR,    3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd18, 32'd3};
    tbl[20] = '{1'b0, C_BR,    3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0010_0000, 32'd19, 32'd3};
    tbl[21] = '{1'b0, C_FEN,   3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd20, 32'd4};
    tbl[22] = '{1'b0, C_FEN,   3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd21, 32'd4};
    tbl[23] = '{1'b0, C_FEN,   3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0010_0000, 32'd22, 32'd4};
    tbl[24] = '{1'b0, C_JAL,   3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd23, 32'd5};
    tbl[25] = '{1'b0, C_JAL,   3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd24, 32'd5};
    tbl[26] = '{1'b0, C_JAL,   3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0000_0000, 32'd25, 32'd5};
    tbl[27] = '{1'b0, C_JAL,   3'd0, 1'b1, 1'b1, 1'b0, S_W, 8'b0011_0000, 32'd26, 32'd5};
    tbl[28] = '{1'b0, C_SYS,   3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd27, 32'd6};
    tbl[29] = '{1'b0, C_SYS,   3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd28, 32'd6};
    tbl[30] = '{1'b0, C_SYS,   3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0000_0000, 32'd29, 32'd6};
    tbl[31] = '{1'b0, C_SYS,   3'd0, 1'b1, 1'b1, 1'b0, S_H, 8'b0000_0010, 32'd30, 32'd6};
    tbl[32] = '{1'b0, C_SYS,   3'd0, 1'b1, 1'b1, 1'b1, S_H, 8'b0010_0010, 32'd31, 32'd6};
    tbl[33] = '{1'b0, C_LUI,   3'd0, 1'b1, 1'b1, 1'b0, S_F, 8'b1100_0000, 32'd32, 32'd7};
    tbl[34] = '{1'b0, C_LUI,   3'd0, 1'b1, 1'b1, 1'b0, S_D, 8'b0000_0000, 32'd33, 32'd7};
    tbl[35] = '{1'b0, C_LUI,   3'd0, 1'b1, 1'b1, 1'b0, S_E, 8'b0000_0000, 32'd34, 32'd7};
    tbl[36] = '{1'b0, C_LUI,   3'd0, 1'b1, 1'b1, 1'b0, S_W, 8'b0011_0000, 32'd35, 32'd7};
    tbl[37] = '{1'b0, C_LUI,   3'd0, 1'b0, 1'b1, 1'b0, S_F, 8'b1000_0000, 32'd36, 32'd8};

    repeat (2) @(posedge clock);

    for (int i = 0; i < 38; i++) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].ir, tbl[i].dr, tbl[i].res);
      check($sformatf("row%0d state", i), {29'd0, state}, {29'd0, tbl[i].st});
      check($sformatf("row%0d strobes", i), {24'd0, strobes()}, {24'd0, tbl[i].strb});
      check($sformatf("row%0d cycle_cnt", i), cycle_cnt, perf(tbl[i].cyc));
      check($sformatf("row%0d instret_cnt", i), instret_cnt, perf(tbl[i].ret));
    end

    // Illegal opcode: HALT on dut, NOP retire on dut0. Both start in FETCH.
    drive(1'b0, C_BAD, 3'd0, 1'b1, 1'b1, 1'b0);
    check("ill fetch ir_we", {31'd0, ir_we}, 32'd1);
    drive(1'b0, C_BAD, 3'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, C_BAD, 3'd0, 1'b0, 1'b1, 1'b0);
    check("ill exec state", {29'd0, state}, {29'd0, S_E});
    check("ill exec pc_we halt", {31'd0, pc_we}, 32'd0);
    check("ill exec pc_we nop", {31'd0, pc_we0}, 32'd1);
    drive(1'b0, C_BAD, 3'd0, 1'b0, 1'b1, 1'b0);
    check("ill halt state", {29'd0, state}, {29'd0, S_H});
    check("ill halt strobes", {24'd0, strobes()}, {24'd0, 8'b0000_0011});
    check("ill nop state", {29'd0, state0}, {29'd0, S_F});
    check("ill nop halted", {31'd0, halted0 | illegal0}, 32'd0);
    drive(1'b0, C_BAD, 3'd0, 1'b0, 1'b1, 1'b1);
    check("ill resume strobes", {24'd0, strobes()}, {24'd0, 8'b0010_0011});
    drive(1'b0, C_BAD, 3'd0, 1'b0, 1'b1, 1'b0);
    check("ill after resume state", {29'd0, state}, {29'd0, S_F});
    check("ill after resume flags", {31'd0, halted | illegal}, 32'd0);

    // Reset while a load is waiting in MEM.
    drive(1'b0, C_LOAD, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_LOAD, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_LOAD, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_LOAD, 3'd0, 1'b1, 1'b0, 1'b0);
    check("rst mem state", {29'd0, state}, {29'd0, S_M});
    check("rst mem dmem_re", {31'd0, dmem_re}, 32'd1);
    drive(1'b1, C_LOAD, 3'd0, 1'b1, 1'b0, 1'b0);
    check("rst cycle strobes", {24'd0, strobes()}, 32'd0);
    drive(1'b0, C_LOAD, 3'd0, 1'b0, 1'b0, 1'b0);
    check("rst after state", {29'd0, state}, {29'd0, S_F});
    check("rst after dmem_re", {31'd0, dmem_re}, 32'd0);
    check("rst after cycle_cnt", cycle_cnt, 32'd0);
    check("rst after instret_cnt", instret_cnt, 32'd0);
    drive(1'b0, C_LOAD, 3'd0, 1'b0, 1'b1, 1'b0);
    check("rst no reissue", {31'd0, dmem_re | dmem_we}, 32'd0);
    check("rst count resumes", cycle_cnt, perf(32'd1));

`ifdef RV32_SEQ_PERF_EN
    // Preload both counters to all-ones, then retire one branch.
    force dut.u_perf.cycle_q   = 32'hFFFF_FFFF;
    force dut.u_perf.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.cycle_q;
    release dut.u_perf.instret_q;
    drive(1'b0, C_BR, 3'd0, 1'b1, 1'b0, 1'b0);
    check("wrap cycle_cnt", cycle_cnt, 32'd0);
    check("wrap instret hold", instret_cnt, 32'hFFFF_FFFF);
    drive(1'b0, C_BR, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_BR, 3'd0, 1'b0, 1'b0, 1'b0);
    check("wrap branch pc_we", {31'd0, pc_we}, 32'd1);
    drive(1'b0, C_BR, 3'd0, 1'b0, 1'b0, 1'b0);
    check("wrap instret_cnt", instret_cnt, 32'd0);
`else
    drive(1'b0, C_BR, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_BR, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_BR, 3'd0, 1'b0, 1'b0, 1'b0);
    check("nocnt branch pc_we", {31'd0, pc_we}, 32'd1);
    drive(1'b0, C_BR, 3'd0, 1'b0, 1'b0, 1'b0);
    check("nocnt cycle_cnt", cycle_cnt, 32'd0);
    check("nocnt instret_cnt", instret_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
